lfsr_decrypt_engine: RTL and testbench

//  Downstream stage of the LFSR encrypter. On a req/ack handshake it reads the 64-byte

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr7_step.sv | 12 +
 rtl/lfsr_decrypt_engine.sv | 172 +++++++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and FSM encoding for the 7-bit LFSR cipher stages.
package lfsr_pkg;

    localparam logic [6:0] TAP_TABLE [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                             7'h69, 7'h5C, 7'h7E, 7'h7B};
    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [3:0] NO_TAP     = 4'hF;
    localparam logic [3:0] LAST_TAP   = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SEARCH,
        DEC_RD,
        DEC_WR,
        DONE
    } state_t;

endpackage

// File: rtl/lfsr7_step.sv
// Purpose: one step of a 7-bit Fibonacci LFSR with a selectable tap mask.
// Latency: combinational.
// Backpressure: none.
module lfsr7_step (
    input  logic [6:0] state,
    input  logic [6:0] taps,
    output logic [6:0] next
);

    assign next = {state[5:0], ^(state & taps)};

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// Purpose: recover LFSR seed/tap from the space preamble, then decrypt ciphertext into plaintext memory.
// Latency: req fall to ack = 2 + search cycles + 2*MSG_LEN + 1 (194 worst case at defaults).
// Backpressure: none; req high aborts to IDLE, ack holds until the next req or init.
module lfsr_decrypt_engine
    import lfsr_pkg::*;
#(
    parameter int MIN_SPACES = 8,
    parameter int MSG_LEN    = 64,
    parameter int CT_BASE    = 64,
    parameter int PT_BASE    = 0
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic [3:0] found_tap,
    output logic       no_match,
    output logic [6:0] parity_errs
);

    localparam logic [7:0] CT_B   = 8'(CT_BASE);
    localparam logic [7:0] PT_B   = 8'(PT_BASE);
    localparam logic [7:0] LAST_I = 8'(MIN_SPACES - 1);
    localparam logic [7:0] LAST_J = 8'(MSG_LEN - 1);

    state_t     state, state_n;
    logic       req_q;
    logic [6:0] seed, seed_n;
    logic [6:0] s, s_n, s_step;
    logic [3:0] k, k_n;
    logic [7:0] i, i_n;
    logic [7:0] j, j_n;
    logic [7:0] rd_q, rd_n;
    logic       ack_n, no_match_n;
    logic [3:0] found_n;
    logic [6:0] perr_n;
    logic [6:0] tap_sel;
    logic [6:0] rd_state;

    assign tap_sel  = (k <= LAST_TAP) ? TAP_TABLE[k] : 7'h00;
    // LFSR state implied by the current read byte if it is a preamble space
    assign rd_state = mem_rd_data[6:0] ^ SPACE_CHAR[6:0];

    lfsr7_step u_step (
        .state (s),
        .taps  (tap_sel),
        .next  (s_step)
    );

    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            seed        <= '0;
            s           <= '0;
            k           <= '0;
            i           <= '0;
            j           <= '0;
            rd_q        <= '0;
            ack         <= 1'b0;
            found_tap   <= '0;
            no_match    <= 1'b0;
            parity_errs <= '0;
        end else begin
            state       <= state_n;
            req_q       <= req;
            seed        <= seed_n;
            s           <= s_n;
            k           <= k_n;
            i           <= i_n;
            j           <= j_n;
            rd_q        <= rd_n;
            ack         <= ack_n;
            found_tap   <= found_n;
            no_match    <= no_match_n;
            parity_errs <= perr_n;
        end
    end

    always_comb begin
        state_n     = state;
        seed_n      = seed;
        s_n         = s;
        k_n         = k;
        i_n         = i;
        j_n         = j;
        rd_n        = rd_q;
        ack_n       = ack;
        found_n     = found_tap;
        no_match_n  = no_match;
        perr_n      = parity_errs;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state)
            IDLE: begin
                if (req_q && !req) state_n = SEED;
            end
            SEED: begin
                mem_addr = CT_B;
                seed_n   = rd_state;
                s_n      = rd_state;
                k_n      = '0;
                i_n      = 8'd1;
                state_n  = SEARCH;
            end
            SEARCH: begin
                mem_addr = CT_B + i;
                if (rd_state == s_step) begin
                    s_n = s_step;
                    if (i == LAST_I) begin
                        found_n = k;
                        s_n     = seed;
                        j_n     = '0;
                        state_n = DEC_RD;
                    end else begin
                        i_n = i + 8'd1;
                    end
                end else if (k == LAST_TAP) begin
                    found_n    = NO_TAP;
                    no_match_n = 1'b1;
                    state_n    = DONE;
                end else begin
                    k_n = k + 4'd1;
                    s_n = seed;
                    i_n = 8'd1;
                end
            end
            DEC_RD: begin
                mem_addr = CT_B + j;
                rd_n     = mem_rd_data;
                state_n  = DEC_WR;
            end
            DEC_WR: begin
                mem_addr  = PT_B + j;
                mem_wr_en = 1'b1;
                // odd parity over the stored byte marks a corrupted ciphertext byte
                if (^rd_q) begin
                    mem_wr_data = 8'h80;
                    perr_n      = parity_errs + 7'd1;
                end else begin
                    mem_wr_data = {1'b0, rd_q[6:0] ^ s};
                end
                s_n = s_step;
                if (j == LAST_J) begin
                    state_n = DONE;
                end else begin
                    j_n     = j + 8'd1;
                    state_n = DEC_RD;
                end
            end
            DONE: begin
                ack_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (req) begin
            state_n    = IDLE;
            ack_n      = 1'b0;
            found_n    = '0;
            no_match_n = 1'b0;
            perr_n     = '0;
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Directed bench for lfsr_decrypt_engine: encrypts known messages into a memory model
// and checks recovered tap, plaintext, parity handling, latency, abort and reset.
module tb_lfsr_decrypt_engine;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic [3:0] found_tap;
    logic       no_match;
    logic [6:0] parity_errs;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;
    int         wr_cnt = 0;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] pt [64];
    logic [7:0] ct [64];

    localparam logic [6:0] TB_TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                           7'h69, 7'h5C, 7'h7E, 7'h7B};

    always #5 clk = ~clk;

    lfsr_decrypt_engine dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .found_tap   (found_tap),
        .no_match    (no_match),
        .parity_errs (parity_errs)
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt        <= wr_cnt + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    function automatic logic [6:0] tb_step(input logic [6:0] st, input logic [6:0] t);
        return {st[5:0], ^(st & t)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1;
        tb_we   = 1'b0;
    endtask

    task automatic make_msg(input int nsp, input int salt);
        string hello;
        hello = "HELLO LFSR WORLD";
        for (int n = 0; n < 64; n++) begin
            if (n < nsp)
                pt[n] = 8'h20;
            else if (salt == 0 && (n - nsp) < hello.len())
                pt[n] = hello[n - nsp];
            else
                pt[n] = 8'h41 + 8'((n * 7 + salt) % 58);
        end
    endtask

    task automatic encrypt(input logic [6:0] seed, input int k);
        logic [6:0] st;
        logic [6:0] c7;
        st = seed;
        for (int n = 0; n < 64; n++) begin
            c7    = st ^ pt[n][6:0];
            ct[n] = {^c7, c7};
            st    = tb_step(st, TB_TAPS[k]);
        end
    endtask

    task automatic load_ct();
        for (int n = 0; n < 64; n++) poke(8'(64 + n), ct[n]);
    endtask

    task automatic fill_pt_area(input logic [7:0] base);
        for (int n = 0; n < 64; n++) poke(8'(n), base ^ 8'(n));
    endtask

    task automatic run(output int lat);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        while (!ack && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_pt(input string tag, input int bad_idx);
        int         nbad;
        logic [7:0] exp;
        nbad = 0;
        for (int n = 0; n < 64; n++) begin
            exp = (n == bad_idx) ? 8'h80 : pt[n];
            if (mem[n] !== exp) nbad++;
        end
        check(tag, 32'(nbad), 32'd0);
    endtask

    initial begin
        int lat;
        int wr0;
        int nchg;
        int n;

        init  = 1'b1;
        req   = 1'b0;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",      32'(ack),         32'd0);
        check("rst_wr_en",    32'(mem_wr_en),   32'd0);
        check("rst_addr",     32'(mem_addr),    32'd0);
        check("rst_wr_data",  32'(mem_wr_data), 32'd0);
        check("rst_tap",      32'(found_tap),   32'd0);
        check("rst_no_match", 32'(no_match),    32'd0);
        check("rst_perr",     32'(parity_errs), 32'd0);
        init = 1'b0;

        // 1: seed 01, tap 0, ten spaces then text; search is 7 cycles -> 2+7+128+1
        make_msg(10, 0);
        encrypt(7'h01, 0);
        load_ct();
        fill_pt_area(8'hC3);
        wr0 = wr_cnt;
        run(lat);
        check("t1_latency",   32'(lat),            32'd138);
        check("t1_by_194",    32'(lat <= 194),     32'd1);
        check("t1_tap",       32'(found_tap),      32'd0);
        check("t1_no_match",  32'(no_match),       32'd0);
        check("t1_perr",      32'(parity_errs),    32'd0);
        check("t1_writes",    32'(wr_cnt - wr0),   32'd64);
        check("t1_space9",    32'(mem[9]),         32'h20);
        check("t1_first_ch",  32'(mem[10]),        32'h48);
        check_pt("t1_plaintext", -1);

        // 2: seed 55, tap 8; taps 0..7 fail after 2,2,1,1,2,1,2,2 compares -> 2+20+128+1
        make_msg(8, 5);
        encrypt(7'h55, 8);
        load_ct();
        fill_pt_area(8'h3C);
        run(lat);
        check("t2_latency",   32'(lat),         32'd151);
        check("t2_tap",       32'(found_tap),   32'd8);
        check("t2_no_match",  32'(no_match),    32'd0);
        check("t2_perr",      32'(parity_errs), 32'd0);
        check_pt("t2_plaintext", -1);

        // 3: corrupt the parity of ciphertext byte 16
        make_msg(8, 11);
        encrypt(7'h12, 0);
        ct[16] = ct[16] ^ 8'h80;
        load_ct();
        fill_pt_area(8'h00);
        run(lat);
        check("t3_latency",   32'(lat),         32'd138);
        check("t3_perr",      32'(parity_errs), 32'd1);
        check("t3_byte16",    32'(mem[16]),     32'h80);
        check_pt("t3_plaintext", 16);

        // 4: byte 1 cannot follow seed 0 under any tap -> 9 single-compare misses
        ct[0] = 8'h20;
        ct[1] = 8'h60;
        for (int m = 2; m < 64; m++) ct[m] = 8'($urandom_range(0, 255));
        load_ct();
        fill_pt_area(8'h5A);
        wr0 = wr_cnt;
        run(lat);
        check("t4_latency",   32'(lat),          32'd12);
        check("t4_ack",       32'(ack),          32'd1);
        check("t4_no_match",  32'(no_match),     32'd1);
        check("t4_tap",       32'(found_tap),    32'hF);
        check("t4_writes",    32'(wr_cnt - wr0), 32'd0);
        nchg = 0;
        for (int m = 0; m < 64; m++) if (mem[m] !== (8'h5A ^ 8'(m))) nchg++;
        check("t4_pt_untouched", 32'(nchg), 32'd0);

        // 5: abort on the byte-20 write, then a clean rerun
        make_msg(9, 23);
        encrypt(7'h2C, 0);
        load_ct();
        fill_pt_area(8'hFF);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        n = 0;
        while (!(mem_wr_en && mem_addr == 8'd20) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_reach_wr20", 32'(n < 400), 32'd1);
        req = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ack_low",   32'(ack),       32'd0);
        check("t5_wr_idle",   32'(mem_wr_en), 32'd0);
        check("t5_addr_idle", 32'(mem_addr),  32'd0);
        check("t5_nm_clear",  32'(no_match),  32'd0);
        wr0 = wr_cnt;
        fill_pt_area(8'hFF);
        check("t5_held_idle", 32'(wr_cnt - wr0), 32'd0);
        check("t5_held_ack",  32'(ack),          32'd0);
        run(lat);
        check("t5_latency",   32'(lat),       32'd138);
        check("t5_tap",       32'(found_tap), 32'd0);
        check_pt("t5_plaintext", -1);

        // 6: one-cycle init while searching
        make_msg(8, 31);
        encrypt(7'h55, 8);
        load_ct();
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_in_search", 32'(mem_addr != 8'd0), 32'd1);
        wr0  = wr_cnt;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("t6_ack",      32'(ack),         32'd0);
        check("t6_wr_en",    32'(mem_wr_en),   32'd0);
        check("t6_addr",     32'(mem_addr),    32'd0);
        check("t6_wr_data",  32'(mem_wr_data), 32'd0);
        check("t6_tap",      32'(found_tap),   32'd0);
        check("t6_no_match", 32'(no_match),    32'd0);
        check("t6_perr",     32'(parity_errs), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("t6_no_writes", 32'(wr_cnt - wr0), 32'd0);
        check("t6_stay_idle", 32'(ack),          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
